// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: bus commands, tag geometry and owner-table entries.
// All consumers import this package rather than relying on global macros.
package mem_bus_arbiter_pkg;

  localparam int NUM_MEM_TAGS = 16;
  localparam int TAG_W        = $clog2(NUM_MEM_TAGS);
  localparam int DATA_SIZE    = 64;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_e;

  typedef enum logic {
    OWNER_DCACHE = 1'b0,
    OWNER_ICACHE = 1'b1
  } mem_owner_e;

  typedef struct packed {
    logic       valid;
    mem_owner_e owner;
  } mem_tag_entry_t;

endpackage

// File: rtl/mem_tag_owner_table.sv
// Per-tag owner table: records which cache issued each accepted memory tag so that
// returning data is routed only to its issuer; flags returns for tags nobody owns.
module mem_tag_owner_table
  import mem_bus_arbiter_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             alloc_en_i,
  input  logic [TAG_W-1:0] alloc_tag_i,
  input  mem_owner_e       alloc_owner_i,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             hit_o,
  output mem_owner_e       hit_owner_o,
  output logic             orphan_err_o
);

  mem_tag_entry_t table_q [NUM_MEM_TAGS];
  mem_tag_entry_t table_d [NUM_MEM_TAGS];
  logic           orphan_q;
  logic           orphan_d;
  logic           lookup_req;

  assign lookup_req = (lookup_tag_i != '0);

  always_comb begin
    table_d     = table_q;
    orphan_d    = orphan_q;
    hit_o       = lookup_req && table_q[lookup_tag_i].valid;
    hit_owner_o = table_q[lookup_tag_i].owner;
    if (hit_o) begin
      table_d[lookup_tag_i].valid = 1'b0;
    end else if (lookup_req) begin
      orphan_d = 1'b1;
    end
    // Applied after the clear so a same-cycle return and re-accept leaves the new owner.
    if (alloc_en_i) begin
      table_d[alloc_tag_i] = '{valid: 1'b1, owner: alloc_owner_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_MEM_TAGS; i++) begin
        table_q[i] <= '0;
      end
      orphan_q <= 1'b0;
    end else begin
      table_q  <= table_d;
      orphan_q <= orphan_d;
    end
  end

  assign orphan_err_o = orphan_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between dcache and icache: dcache has priority, a starvation
// counter forces an icache grant, and returning tags are routed back to their issuer.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  bus_command_e         dcache2mem_command_i,
  input  logic [31:0]          dcache2mem_addr_i,
  input  logic [DATA_SIZE-1:0] dcache2mem_data_i,
  input  bus_command_e         icache2mem_command_i,
  input  logic [31:0]          icache2mem_addr_i,
  input  logic [TAG_W-1:0]     mem2proc_response_i,
  input  logic [DATA_SIZE-1:0] mem2proc_data_i,
  input  logic [TAG_W-1:0]     mem2proc_tag_i,
  output bus_command_e         proc2mem_command_o,
  output logic [31:0]          proc2mem_addr_o,
  output logic [DATA_SIZE-1:0] proc2mem_data_o,
  output logic [TAG_W-1:0]     mem2dcache_response_o,
  output logic [TAG_W-1:0]     mem2dcache_tag_o,
  output logic [DATA_SIZE-1:0] mem2dcache_data_o,
  output logic [TAG_W-1:0]     mem2icache_response_o,
  output logic [TAG_W-1:0]     mem2icache_tag_o,
  output logic [DATA_SIZE-1:0] mem2icache_data_o,
  output logic                 orphan_tag_err_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             dcache_req;
  logic             icache_req;
  logic             force_icache;
  logic             grant_dc;
  logic             grant_ic;
  logic             alloc_en;
  logic             ret_hit;
  mem_owner_e       ret_owner;

  assign dcache_req   = (dcache2mem_command_i != BUS_NONE);
  assign icache_req   = (icache2mem_command_i != BUS_NONE);
  assign force_icache = (starve_q == STARVE_MAX);
  assign grant_dc     = dcache_req && !(force_icache && icache_req);
  assign grant_ic     = icache_req && !grant_dc;

  always_comb begin
    proc2mem_command_o = BUS_NONE;
    proc2mem_addr_o    = '0;
    proc2mem_data_o    = '0;
    if (grant_dc) begin
      proc2mem_command_o = dcache2mem_command_i;
      proc2mem_addr_o    = dcache2mem_addr_i;
      proc2mem_data_o    = dcache2mem_data_i;
    end else if (grant_ic) begin
      proc2mem_command_o = icache2mem_command_i;
      proc2mem_addr_o    = icache2mem_addr_i;
    end
  end

  assign mem2dcache_response_o = grant_dc ? mem2proc_response_i : '0;
  assign mem2icache_response_o = grant_ic ? mem2proc_response_i : '0;

  // Counts denied grant cycles, independent of whether memory accepted the command.
  always_comb begin
    starve_d = '0;
    if (icache_req && !grant_ic) begin
      starve_d = force_icache ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign alloc_en = (grant_dc || grant_ic) && (mem2proc_response_i != '0);

  mem_tag_owner_table u_owner_table (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .alloc_en_i   (alloc_en),
    .alloc_tag_i  (mem2proc_response_i),
    .alloc_owner_i(grant_ic ? OWNER_ICACHE : OWNER_DCACHE),
    .lookup_tag_i (mem2proc_tag_i),
    .hit_o        (ret_hit),
    .hit_owner_o  (ret_owner),
    .orphan_err_o (orphan_tag_err_o)
  );

  assign mem2dcache_tag_o  = (ret_hit && ret_owner == OWNER_DCACHE) ? mem2proc_tag_i : '0;
  assign mem2icache_tag_o  = (ret_hit && ret_owner == OWNER_ICACHE) ? mem2proc_tag_i : '0;
  assign mem2dcache_data_o = mem2proc_data_i;
  assign mem2icache_data_o = mem2proc_data_i;

endmodule
